mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (read-only word fetches) and the memory stage (loads/stores, word or byte).
- Three-state FSM sequences one memory transaction at a time over a req/ack handshake.
- Data accesses get priority; a streak counter prevents fetch starvation.
- Produces per-requester done strobes; the pipeline stall logic uses these to hold IF or MEM.

Parameters:
- MAX_DM_STREAK, 4: maximum consecutive data grants while fetch waits before fetch is forced through (range 1..2^STREAK_W-1).
- STREAK_W, 3: width of the streak counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_done or if_flush
- if_addr  in  32  fetch word address (byte address, [1:0] ignored)
- if_flush  in  1  fetch redirect pulse; current fetch result is unwanted
- if_done  out  1  fetch complete strobe, one cycle
- if_rdata  out  32  fetch data, valid only when if_done=1
- dm_req  in  1  data request; held with dm_* stable until dm_done
- dm_we  in  1  1=store, 0=load
- dm_byte  in  1  byte access
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_done  out  1  data complete strobe, one cycle
- dm_rdata  out  32  load data, valid only when dm_done=1
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_byte  out  1  byte access, registered
- mem_addr  out  32  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_ack  in  1  single-cycle completion from memory; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, immediate) sets:
  - state=IDLE, streak=0, drop=0.
  - mem_req, mem_we, mem_byte, if_done, dm_done, busy = 0.
  - mem_addr, mem_wdata = 0.
  - An in-flight transaction is abandoned; memory is reset by the same rst_n.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration, evaluated every cycle:
  - Only dm_req: go to BUSY_DM.
  - Only if_req with if_flush=0: go to BUSY_IF.
  - Both: BUSY_DM unless streak==MAX_DM_STREAK, in which case BUSY_IF.
  - Neither: stay in IDLE.
  - if_req with if_flush=1 in the same cycle is ignored for that cycle.
- Grant action: on the transition edge, register mem_req=1 and copy the winner's fields onto mem_*.
  - Fetch grants drive mem_we=0, mem_byte=0, mem_addr={if_addr[31:2],2'b00}.
- BUSY_x:
  - mem_* held constant until mem_ack.
  - On mem_ack: mem_req cleared on the next edge, state returns to IDLE, and x_done is asserted combinationally in the ack cycle.
  - x_rdata = mem_rdata, passed through.
- Minimum latency: request seen in cycle N, mem_req high in N+1, done in N+1 if memory acks immediately. Next arbitration occurs in N+2.
- Requesters deassert or change their request in the cycle after done. The arbiter never re-samples a request in the done cycle, because the FSM is still in BUSY that cycle.
- Streak counter, updated on each grant:
  - Data grant while if_req=1: streak+1, saturating at MAX_DM_STREAK.
  - Data grant while if_req=0, or any fetch grant: streak=0.
- Flush:
  - if_flush in BUSY_IF sets drop=1. The memory transaction still completes (no abort on the bus), but if_done is suppressed.
  - drop clears on return to IDLE.
  - if_flush in the ack cycle also suppresses if_done.
  - if_flush has no effect in BUSY_DM.
- if_done and dm_done are never both high.
- mem_we is never high during a fetch transaction.
- mem_ack while state=IDLE is ignored and produces no done.

Decomposition:
- Shared package/defines file holds:
  - State encodings ARB_IDLE=2'd0, ARB_BUSY_IF=2'd1, ARB_BUSY_DM=2'd2.
  - Default MAX_DM_STREAK.
- One natural sub-module: arb_streak_counter (saturating counter with clear/increment and an at_max flag).
- FSM and the memory-side output registers stay in the top module.

Test Plan:
- Only if_req, if_addr=0x0000_0043, memory acks 1 cycle after mem_req → mem_addr=0x0000_0040, mem_we=0; if_done high 1 cycle with if_rdata=mem_rdata=0xDEAD_BEEF; dm_done stays 0.
- if_req and dm_req (dm_we=1, dm_byte=1, dm_addr=0x100, dm_wdata=0xAB) rise together → data served first (mem_we=1, mem_byte=1, mem_addr=0x100), then fetch; 2 transactions total.
- dm_req held continuously for 6 transactions with if_req high throughout, MAX_DM_STREAK=4 → grant order DM, DM, DM, DM, IF, DM, DM; streak returns to 0 after the IF grant.
- if_flush pulsed mid-BUSY_IF with a 3-cycle memory latency → mem_ack occurs, if_done stays 0, FSM returns to IDLE; the next if_req with a new address is served normally.
- rst_n asserted low while in BUSY_DM with mem_req=1 → mem_req, busy and done outputs drop to 0 without waiting for a clock edge; after release, state=IDLE and streak=0.
- Memory holds mem_ack low for 10 cycles → mem_addr, mem_wdata and mem_we are stable throughout, no done is asserted, and a second requester waits.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_t            : arbiter FSM state encoding
//   DEFAULT_MAX_DM_STREAK  : default cap on back-to-back data grants while fetch waits
//   DEFAULT_STREAK_W       : default width of the streak counter
//   ADDR_W / DATA_W        : memory bus address and data widths
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_DM_STREAK = 4;
  localparam int DEFAULT_STREAK_W      = 3;
  localparam int ADDR_W                = 32;
  localparam int DATA_W                = 32;

endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (takes priority over inc)
//   inc        : add one, holding at MAX_DM_STREAK
//   count      : current streak
//   at_max     : count has reached MAX_DM_STREAK; the next contested grant goes to fetch
module arb_streak_counter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int STREAK_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [STREAK_W-1:0] count,
  output logic                at_max
);

  localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX_DM_STREAK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + STREAK_W'(1);
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data
// (load/store) stage. One transaction at a time over a registered req / single
// cycle ack handshake. Data wins contested cycles unless it already won
// MAX_DM_STREAK times in a row while fetch waited.
//   Fetch side : if_req, if_addr, if_flush -> if_done, if_rdata
//   Data side  : dm_req, dm_we, dm_byte, dm_addr, dm_wdata -> dm_done, dm_rdata
//   Memory side: mem_req, mem_we, mem_byte, mem_addr, mem_wdata (registered)
//                <- mem_ack, mem_rdata
//   busy       : a transaction is outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = DEFAULT_MAX_DM_STREAK,
  parameter int STREAK_W      = DEFAULT_STREAK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t          state;
  arb_state_t          state_nx;
  logic                drop;
  logic                if_want;
  logic                grant_dm;
  logic                grant_if;
  logic                txn_end;
  logic                streak_at_max;
  logic [STREAK_W-1:0] streak;
  logic                unused_addr_lsb;

  // Fetches are always whole words; the byte offset is discarded.
  assign unused_addr_lsb = ^if_addr[1:0];

  // A fetch request accompanied by a flush is not a request this cycle.
  assign if_want  = if_req & ~if_flush;
  assign grant_dm = (state == ARB_IDLE) && dm_req && !(if_want && streak_at_max);
  assign grant_if = (state == ARB_IDLE) && if_want && (!dm_req || streak_at_max);
  // mem_ack only means something while a transaction is outstanding.
  assign txn_end  = (state != ARB_IDLE) && mem_ack;

  arb_streak_counter #(
    .MAX_DM_STREAK(MAX_DM_STREAK),
    .STREAK_W     (STREAK_W)
  ) u_streak (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (grant_if || (grant_dm && !if_req)),
    .inc   (grant_dm && if_req),
    .count (streak),
    .at_max(streak_at_max)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: begin
        if (grant_dm) begin
          state_nx = ARB_BUSY_DM;
        end else if (grant_if) begin
          state_nx = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (mem_ack) begin
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Output logic: done strobes are combinational in the ack cycle so the
  // pipeline can release its stall without an extra bubble.
  always_comb begin
    if_done = (state == ARB_BUSY_IF) && mem_ack && !drop && !if_flush;
    dm_done = (state == ARB_BUSY_DM) && mem_ack;
    busy    = (state != ARB_IDLE);
  end

  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

  // A flushed fetch still runs to completion on the bus; drop only hides
  // its done strobe. It is cleared as the FSM heads back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (txn_end) begin
      drop <= 1'b0;
    end else if ((state == ARB_BUSY_IF) && if_flush) begin
      drop <= 1'b1;
    end
  end

  // Memory-side registers: loaded on the grant edge, frozen until ack.
  // mem_wdata is left untouched by fetch grants since mem_we is 0 then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_dm) begin
      mem_req   <= 1'b1;
      mem_we    <= dm_we;
      mem_byte  <= dm_byte;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
    end else if (txn_end) begin
      mem_req   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int MAXS = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_byte, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_byte, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .STREAK_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat = 0;     // negative: random 0..3 per transaction
  int          mem_cnt = 0;
  int          cur_lat = 0;
  bit          spur_en = 0;
  bit          rd_fixed_en = 0;
  logic [31:0] rd_fixed = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (mem_cnt == 0) cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (mem_cnt == cur_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_fixed_en ? rd_fixed : $urandom;
        end
        mem_cnt++;
      end else begin
        mem_cnt = 0;
        if (spur_en && ($urandom_range(0, 5) == 0)) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_owner = 0;     // 0 none, 1 fetch, 2 data
  int          m_streak = 0;
  bit          m_drop = 0;
  bit          m_we = 0, m_byte = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  initial begin
    bit fw;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_dm_done", 32'(dm_done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_byte", 32'(mem_byte), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end else begin
        chk("busy", 32'(busy), 32'(m_owner != 0));
        chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
        chk("if_done", 32'(if_done), 32'(m_owner == 1 && mem_ack && !m_drop && !if_flush));
        chk("dm_done", 32'(dm_done), 32'(m_owner == 2 && mem_ack));
        if (m_owner != 0) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_we", 32'(mem_we), 32'(m_we));
          chk("mem_byte", 32'(mem_byte), 32'(m_byte));
          if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (if_done === 1'b1) chk("if_rdata", if_rdata, mem_rdata);
        if (dm_done === 1'b1) chk("dm_rdata", dm_rdata, mem_rdata);
      end
      @(posedge clk);
      if (!rst_n) begin
        m_owner = 0; m_streak = 0; m_drop = 0;
      end else if (m_owner == 0) begin
        fw = if_req && !if_flush;
        if (dm_req && !(fw && m_streak == MAXS)) begin
          m_owner = 2; m_addr = dm_addr; m_wdata = dm_wdata;
          m_we = dm_we; m_byte = dm_byte;
          m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
        end else if (fw) begin
          m_owner = 1; m_addr = if_addr & 32'hFFFF_FFFC;
          m_we = 0; m_byte = 0; m_streak = 0;
        end
      end else if (mem_ack) begin
        m_owner = 0; m_drop = 0;
      end else if (m_owner == 1 && if_flush) begin
        m_drop = 1;
      end
    end
  end

  // ---------------- directed-test helpers ----------------
  logic [31:0] g_addr[$], g_wdata[$];
  bit          g_we[$], g_byte[$];
  int          g_if_done, g_dm_done;
  logic [31:0] g_if_rdata;
  bit          prev_req, keep_if, keep_dm;

  task automatic clear_rec();
    g_addr.delete(); g_wdata.delete(); g_we.delete(); g_byte.delete();
    g_if_done = 0; g_dm_done = 0; g_if_rdata = '0; prev_req = 0;
  endtask

  // Called at a falling edge; runs n cycles, recording grants and done strobes.
  task automatic run_cycles(input int n);
    bit id, dd;
    for (int i = 0; i < n; i++) begin
      #3;
      if (mem_req && !prev_req) begin
        g_addr.push_back(mem_addr); g_wdata.push_back(mem_wdata);
        g_we.push_back(mem_we); g_byte.push_back(mem_byte);
      end
      prev_req = mem_req;
      id = if_done; dd = dm_done;
      if (id) begin g_if_done++; g_if_rdata = if_rdata; end
      if (dd) g_dm_done++;
      @(negedge clk);
      if (id && !keep_if) if_req = 1'b0;
      if (dd && !keep_dm) dm_req = 1'b0;
    end
  endtask

  logic [31:0] exp_c[8];

  initial begin
    bit id, dd;
    rst_n = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_byte = 0; dm_addr = '0; dm_wdata = '0;
    keep_if = 0; keep_dm = 0;
    clear_rec();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A: lone fetch, unaligned address
    clear_rec();
    mem_lat = 1; rd_fixed_en = 1; rd_fixed = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h0000_0043;
    run_cycles(6);
    chk("A_grants", 32'(g_addr.size()), 32'd1);
    if (g_addr.size() >= 1) begin
      chk("A_addr", g_addr[0], 32'h0000_0040);
      chk("A_we", 32'(g_we[0]), 32'd0);
    end
    chk("A_if_done_cnt", 32'(g_if_done), 32'd1);
    chk("A_if_rdata", g_if_rdata, 32'hDEAD_BEEF);
    chk("A_dm_done_cnt", 32'(g_dm_done), 32'd0);
    rd_fixed_en = 0;

    // B: simultaneous requests, data first
    clear_rec();
    if_req = 1; if_addr = 32'h1000;
    dm_req = 1; dm_we = 1; dm_byte = 1; dm_addr = 32'h100; dm_wdata = 32'hAB;
    run_cycles(10);
    chk("B_grants", 32'(g_addr.size()), 32'd2);
    if (g_addr.size() >= 2) begin
      chk("B_g0_addr", g_addr[0], 32'h100);
      chk("B_g0_we", 32'(g_we[0]), 32'd1);
      chk("B_g0_byte", 32'(g_byte[0]), 32'd1);
      chk("B_g0_wdata", g_wdata[0], 32'hAB);
      chk("B_g1_addr", g_addr[1], 32'h1000);
      chk("B_g1_we", 32'(g_we[1]), 32'd0);
    end
    chk("B_dm_done_cnt", 32'(g_dm_done), 32'd1);
    chk("B_if_done_cnt", 32'(g_if_done), 32'd1);

    // C: data streak cap forces fetch through
    clear_rec();
    mem_lat = 0; keep_if = 1; keep_dm = 1;
    if_req = 1; if_addr = 32'h1000;
    dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h2000;
    run_cycles(14);
    dm_req = 0; keep_if = 0; keep_dm = 0;
    run_cycles(6);
    exp_c = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
    chk("C_grants", 32'(g_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < g_addr.size()) chk($sformatf("C_order%0d", i), g_addr[i], exp_c[i]);

    // D: flush during fetch
    clear_rec();
    mem_lat = 3;
    if_req = 1; if_addr = 32'h200;
    run_cycles(2);
    if_flush = 1; if_req = 0;
    run_cycles(1);
    if_flush = 0;
    run_cycles(6);
    chk("D_if_done_cnt", 32'(g_if_done), 32'd0);
    chk("D_grants", 32'(g_addr.size()), 32'd1);
    chk("D_busy_after", 32'(busy), 32'd0);
    clear_rec();
    mem_lat = 0;
    if_req = 1; if_addr = 32'h300;
    run_cycles(4);
    chk("D_refetch_done", 32'(g_if_done), 32'd1);
    if (g_addr.size() >= 1) chk("D_refetch_addr", g_addr[0], 32'h300);

    // E: slow memory, second requester waits
    clear_rec();
    mem_lat = 10;
    dm_req = 1; dm_we = 1; dm_byte = 0; dm_addr = 32'h2000; dm_wdata = 32'h5555_AAAA;
    if_req = 1; if_addr = 32'h3000;
    run_cycles(10);
    chk("E_no_dm_done", 32'(g_dm_done), 32'd0);
    chk("E_no_if_done", 32'(g_if_done), 32'd0);
    chk("E_grants_wait", 32'(g_addr.size()), 32'd1);
    chk("E_hold_addr", mem_addr, 32'h2000);
    chk("E_hold_wdata", mem_wdata, 32'h5555_AAAA);
    chk("E_hold_we", 32'(mem_we), 32'd1);
    mem_lat = 0;
    run_cycles(6);
    chk("E_dm_done", 32'(g_dm_done), 32'd1);
    chk("E_if_done", 32'(g_if_done), 32'd1);
    if (g_addr.size() >= 2) chk("E_g1_addr", g_addr[1], 32'h3000);

    // F: asynchronous reset in BUSY_DM with the streak at its cap
    clear_rec();
    mem_lat = 0; keep_if = 1; keep_dm = 1;
    if_req = 1; if_addr = 32'h1000;
    dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h4000;
    run_cycles(6);
    mem_lat = 10;
    run_cycles(2);
    #3;
    chk("F_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("F_async_mem_req", 32'(mem_req), 32'd0);
    chk("F_async_busy", 32'(busy), 32'd0);
    chk("F_async_dm_done", 32'(dm_done), 32'd0);
    chk("F_async_if_done", 32'(if_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_lat = 0;
    clear_rec();
    run_cycles(4);
    if (g_addr.size() >= 1) chk("F_first_after_rst", g_addr[0], 32'h4000);
    else chk("F_first_after_rst", 32'hFFFF_FFFF, 32'h4000);
    dm_req = 0; keep_if = 0; keep_dm = 0;
    run_cycles(6);

    // Random phase against the model
    if_req = 0; dm_req = 0; if_flush = 0;
    mem_lat = -1; spur_en = 1;
    for (int c = 0; c < 4000; c++) begin
      #3;
      id = if_done; dd = dm_done;
      @(negedge clk);
      if_flush = 0;
      if (if_req) begin
        if (id) begin
          if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          if_flush = 1; if_req = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end else if ($urandom_range(0, 31) == 0) begin
        if_flush = 1;
      end
      if (dm_req) begin
        if (dd) begin
          dm_req = 1'($urandom_range(0, 3) != 0);
          dm_we = 1'($urandom); dm_byte = 1'($urandom);
          dm_addr = $urandom; dm_wdata = $urandom;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req = 1; dm_we = 1'($urandom); dm_byte = 1'($urandom);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end

    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
